// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder: assembles SYNC/CMD/HI/LO/CHK frames from UART bytes,
// checks the XOR checksum and aborts partial frames on inter-byte timeout.
module uart_frame_decoder #(
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         TIMEOUT_CYC = 650000,
    localparam int        CNT_W       = $clog2(TIMEOUT_CYC)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_done_tick,
    input  logic [7:0]  din,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, GET_CMD, GET_HI, GET_LO, GET_CHK} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         chk_q, chk_d, cmd_h_q, cmd_h_d, hi_q, hi_d, lo_q, lo_d;
    logic [7:0]         cmd_q, cmd_d;
    logic [15:0]        data_q, data_d;
    logic               valid_q, valid_d, err_q, err_d, busy_q, busy_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            chk_q   <= '0;
            cmd_h_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cmd_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            chk_q   <= chk_d;
            cmd_h_q <= cmd_h_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cmd_q   <= cmd_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        chk_d   = chk_q;
        cmd_h_d = cmd_h_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cmd_d   = cmd_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        // a tick in the threshold cycle wins over the timeout abort
        if (state_q == IDLE || rx_done_tick)
            cnt_d = '0;
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            state_d = IDLE;
            cnt_d   = '0;
            err_d   = 1'b1;
        end else
            cnt_d = cnt_q + CNT_W'(1);
        if (rx_done_tick) begin
            case (state_q)
                IDLE: if (din == SYNC_BYTE) begin
                    state_d = GET_CMD;
                    chk_d   = '0;
                end
                GET_CMD: begin
                    cmd_h_d = din;
                    chk_d   = din;
                    state_d = GET_HI;
                end
                GET_HI: begin
                    hi_d    = din;
                    chk_d   = chk_q ^ din;
                    state_d = GET_LO;
                end
                GET_LO: begin
                    lo_d    = din;
                    chk_d   = chk_q ^ din;
                    state_d = GET_CHK;
                end
                GET_CHK: begin
                    state_d = IDLE;
                    if (din == chk_q) begin
                        cmd_d   = cmd_h_q;
                        data_d  = {hi_q, lo_q};
                        valid_d = 1'b1;
                    end else
                        err_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = state_d != IDLE;
    end

    assign frame_valid = valid_q;
    assign frame_err   = err_q;
    assign cmd         = cmd_q;
    assign data        = data_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_uart_frame_decoder.sv
// tb_uart_frame_decoder: directed frames with a scoreboard queue; a monitor
// pops the expected pulse (kind, cmd, data, cycle) whenever one appears.
module tb_uart_frame_decoder;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_done_tick = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        frame_valid, frame_err, busy;
    logic [7:0]  cmd;
    logic [15:0] data;

    typedef struct {
        logic [1:0]  kind;
        logic [7:0]  cmd;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_e = 0;

    uart_frame_decoder #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .din(din),
        .frame_valid(frame_valid), .frame_err(frame_err), .cmd(cmd),
        .data(data), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // caller sits at a negedge; the tick is sampled by the next posedge
    task automatic tick(input logic [7:0] b);
        rx_done_tick = 1'b1;
        din = b;
        last_e = cyc + 1;
        @(negedge clk);
        rx_done_tick = 1'b0;
        din = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(input logic [1:0] kind, input logic [7:0] c,
                                input logic [15:0] d, input int e);
        exp_t x;
        x.kind = kind;
        x.cmd = c;
        x.data = d;
        x.cyc = e;
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (reset && (frame_valid || frame_err)) begin
            if (q.size() == 0)
                chk("unexpected_pulse", {frame_valid, frame_err}, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_kind", {frame_valid, frame_err}, e.kind);
                chk("pulse_cmd", cmd, e.cmd);
                chk("pulse_data", data, e.data);
                chk("pulse_cycle", cyc, e.cyc);
                chk("pulse_busy", busy, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle(2);
        reset = 1'b1;
        idle(1);
        chk("rst_valid", frame_valid, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_cmd", cmd, 0);
        chk("rst_data", data, 0);
        chk("rst_busy", busy, 0);

        // good frame, then bad checksum back-to-back
        tick(8'hA5);
        chk("busy_after_sync", busy, 1);
        tick(8'h01); tick(8'h12); tick(8'h34); tick(8'h27);
        expect_pulse(2'b10, 8'h01, 16'h1234, last_e);
        tick(8'hA5); tick(8'h01); tick(8'h12); tick(8'h34); tick(8'h28);
        expect_pulse(2'b01, 8'h01, 16'h1234, last_e);
        idle(2);

        // garbage then SYNC used as data
        tick(8'h00); tick(8'hFF);
        chk("garbage_busy", busy, 0);
        tick(8'hA5); tick(8'hA5); tick(8'h00); tick(8'h00); tick(8'hA5);
        expect_pulse(2'b10, 8'hA5, 16'h0000, last_e);
        idle(2);

        // timeout abort then good frame
        tick(8'hA5); tick(8'h07);
        expect_pulse(2'b01, 8'hA5, 16'h0000, last_e + 16);
        idle(20);
        tick(8'hA5); tick(8'h02); tick(8'h00); tick(8'h01); tick(8'h03);
        expect_pulse(2'b10, 8'h02, 16'h0001, last_e);
        idle(2);

        // tick lands exactly in the threshold cycle
        tick(8'hA5); tick(8'h07);
        idle(15);
        chk("threshold_busy", busy, 1);
        tick(8'h10); tick(8'h00); tick(8'h17);
        expect_pulse(2'b10, 8'h07, 16'h1000, last_e);
        idle(3);

        // reset mid-frame
        tick(8'hA5); tick(8'h01); tick(8'h12);
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        chk("midrst_valid", frame_valid, 0);
        chk("midrst_err", frame_err, 0);
        chk("midrst_cmd", cmd, 0);
        chk("midrst_data", data, 0);
        chk("midrst_busy", busy, 0);
        tick(8'hA5); tick(8'h03); tick(8'hAB); tick(8'hCD); tick(8'h65);
        expect_pulse(2'b10, 8'h03, 16'hABCD, last_e);
        idle(5);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
